// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared state type and sizing helpers for the carry-save resolver
//
// Purpose: types and elaboration helpers imported by csa_resolver.
//   state_t   : resolver FSM encoding (IDLE, ADD, DONE)
//   num_chunk : number of ChunkDw-wide slices in a DataDw word
//   dims_ok   : true when DataDw is a nonzero multiple of ChunkDw
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_chunk(input int data_dw, input int chunk_dw);
    // Guard the divide so a bad parameter set reaches the dims_ok check
    // instead of failing inside constant evaluation.
    return (chunk_dw > 0) ? (data_dw / chunk_dw) : 1;
  endfunction

  function automatic bit dims_ok(input int data_dw, input int chunk_dw);
    return (chunk_dw > 0) && (data_dw >= chunk_dw) && ((data_dw % chunk_dw) == 0);
  endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// rtl/csa_chunk_adder.sv - combinational W-bit adder with carry in and carry out
//
// Ports:
//   a, b  in  W  addends
//   cin   in  1  carry in
//   s     out W  (a + b + cin) mod 2^W
//   cout  out 1  carry out of bit W-1
module csa_chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - resolves a carry-save pair into one binary word, ChunkDw bits per cycle
//
// Ports:
//   clk_i        in  1       clock
//   rst_ni       in  1       asynchronous active-low reset
//   in_valid_i   in  1       input pair valid
//   in_ready_o   out 1       block can accept an input pair (high in IDLE)
//   sum_i        in  DataDw  carry-save sum word
//   carry_i      in  DataDw  carry-save carry word, already left-shifted
//   out_valid_o  out 1       result valid (high in DONE)
//   out_ready_i  in  1       downstream accepts the result
//   result_o     out DataDw  (sum_i + carry_i) mod 2^DataDw
//   cout_o       out 1       carry out of bit DataDw-1
module csa_resolver #(
  parameter int DataDw  = 16,
  parameter int ChunkDw = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DataDw-1:0] sum_i,
  input  logic [DataDw-1:0] carry_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DataDw-1:0] result_o,
  output logic              cout_o
);

  import csa_pkg::*;

  localparam int NumChunk = num_chunk(DataDw, ChunkDw);
  localparam int CntW     = (NumChunk > 1) ? $clog2(NumChunk) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumChunk - 1);

  if (!dims_ok(DataDw, ChunkDw)) begin : g_bad_dims
    $error("csa_resolver: DataDw must be a nonzero multiple of ChunkDw");
  end

  state_t state_q, state_d;

  logic [DataDw-1:0]  sum_q;
  logic [DataDw-1:0]  carry_q;
  logic [DataDw-1:0]  result_q;
  logic               cout_q;
  logic [CntW-1:0]    cnt_q;
  logic               cbit_q;

  logic [31:0]        base;
  logic [ChunkDw-1:0] chunk_a;
  logic [ChunkDw-1:0] chunk_b;
  logic [ChunkDw-1:0] chunk_s;
  logic               chunk_cout;

  // Bit offset of the slice being resolved this cycle.
  assign base    = 32'(cnt_q) * 32'(ChunkDw);
  assign chunk_a = sum_q[base +: ChunkDw];
  assign chunk_b = carry_q[base +: ChunkDw];

  csa_chunk_adder #(
    .W(ChunkDw)
  ) u_chunk_adder (
    .a   (chunk_a),
    .b   (chunk_b),
    .cin (cbit_q),
    .s   (chunk_s),
    .cout(chunk_cout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_d = ADD;
        end
      end
      ADD: begin
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      cbit_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            sum_q    <= sum_i;
            carry_q  <= carry_i;
            result_q <= '0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
            cbit_q   <= 1'b0;
          end
        end
        ADD: begin
          result_q[base +: ChunkDw] <= chunk_s;
          cbit_q                    <= chunk_cout;
          // The counter parks on the last slice so a single-slice build
          // never needs a value wider than its one bit.
          if (cnt_q == LastCnt) begin
            cout_q <= chunk_cout;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign cout_o   = cout_q;

endmodule

// File: tb/tb_csa_resolver.sv
// tb/tb_csa_resolver.sv - scoreboard bench for csa_resolver
module tb_csa_resolver;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (defaults)
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] sum_in = '0;
  logic [W-1:0] carry_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout;

  csa_resolver u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .sum_i      (sum_in),
    .carry_i    (carry_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .cout_o     (cout)
  );

  // Boundary instances: one slice of 16 bits, and sixteen slices of 1 bit
  logic         ab_valid = 1'b0;
  logic         one = 1'b1;
  logic [W-1:0] a_sum = '0, a_car = '0, b_sum = '0, b_car = '0;
  logic         a_rdy, a_ov, a_co, b_rdy, b_ov, b_co;
  logic [W-1:0] a_res, b_res;

  csa_resolver #(.DataDw(16), .ChunkDw(16)) u_c16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(ab_valid), .in_ready_o(a_rdy),
    .sum_i(a_sum), .carry_i(a_car), .out_valid_o(a_ov), .out_ready_i(one),
    .result_o(a_res), .cout_o(a_co)
  );

  csa_resolver #(.DataDw(16), .ChunkDw(1)) u_c1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(ab_valid), .in_ready_o(b_rdy),
    .sum_i(b_sum), .carry_i(b_car), .out_valid_o(b_ov), .out_ready_i(one),
    .result_o(b_res), .cout_o(b_co)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // out_ready driver: forced level for directed tests, random for regression
  logic rand_rdy = 1'b0;
  logic force_rdy = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  logic [16:0] exp_q[$];
  int last_acc = 0;

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
    int guard;
    guard = 0;
    @(negedge clk);
    sum_in = s;
    carry_in = c;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      exp_q.push_back({1'b0, s} + {1'b0, c});
      @(posedge clk);
      #1;
      last_acc = cyc;
    end
    in_valid = 1'b0;
    // Scramble the inputs to show they are not sampled after acceptance
    sum_in = W'($urandom);
    carry_in = W'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops on every handshake, checks latency and hold-under-backpressure
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [16:0] prev_o = '0;
  logic [16:0] exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_data", 32'({cout, result}), 32'(prev_o));
      end
      if (out_valid && !prev_v) begin
        check("latency", 32'(cyc - last_acc), 32'(4));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(1), 32'(0));
        end else begin
          exp_v = exp_q.pop_front();
          check("result", 32'({cout, result}), 32'(exp_v));
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_o = {cout, result};
    end
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int a_lat, b_lat, t0, guard;
    logic [16:0] a_got, b_got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result", 32'({cout, result}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'(1));

    // Basic resolves: 0x1234+0x0F0F=0x2143, full ripple 0xFFFF+1
    send(16'h1234, 16'h0F0F);
    send(16'hFFFF, 16'h0001);
    drain();

    // Backpressure: 0xAAAA+0x5555 held in DONE for 5 cycles
    force_rdy = 1'b0;
    send(16'hAAAA, 16'h5555);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_reached_done", 32'(out_valid), 32'(1));
    in_valid = 1'b1;
    sum_in = 16'h0001;
    carry_in = 16'h0001;
    repeat (5) begin
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_result", 32'({cout, result}), 32'h0FFFF);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      @(negedge clk);
    end
    force_rdy = 1'b1;
    send(16'h0001, 16'h0001);
    drain();

    // Boundary slice widths
    check("c16_ready", 32'(a_rdy), 32'(1));
    check("c1_ready", 32'(b_rdy), 32'(1));
    @(negedge clk);
    a_sum = 16'h8000;
    a_car = 16'h8000;
    b_sum = 16'h7FFF;
    b_car = 16'h0001;
    ab_valid = 1'b1;
    @(posedge clk);
    #1;
    ab_valid = 1'b0;
    t0 = cyc;
    a_lat = -1;
    b_lat = -1;
    a_got = '0;
    b_got = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_ov && a_lat < 0) begin
        a_lat = cyc - t0;
        a_got = {a_co, a_res};
      end
      if (b_ov && b_lat < 0) begin
        b_lat = cyc - t0;
        b_got = {b_co, b_res};
      end
    end
    check("c16_latency", 32'(a_lat), 32'(1));
    check("c16_result", 32'(a_got), 32'h10000);
    check("c1_latency", 32'(b_lat), 32'(16));
    check("c1_result", 32'(b_got), 32'h08000);

    // Reset in the middle of ADD (counter = 2)
    send(16'h1111, 16'h2222);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_result", 32'({cout, result}), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_output", 32'(out_valid), 32'(0));
    end
    send(16'h0003, 16'h0004);
    drain();

    // Random regression with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom), W'($urandom));
    end
    drain();
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
